// File: rtl/line_ring_buffer_pkg.sv
// line_ring_buffer_pkg
//   Shared constants and helpers for the raster line ring buffer and the
//   block-matching stages that consume its columns.
//   - calc_line_num : number of lines the ring must hold for a given block and
//                     search-window radius.
//   - img_width_ok  : legal range of the active line width for an address width.
package line_ring_buffer_pkg;

    // Lines held in the ring: a full window of rows above and below the centre.
    function automatic int calc_line_num(input int block_radius, input int win_radius);
        return 2 * (block_radius + win_radius + 1);
    endfunction

    // A line needs at least two pixels and must fit the line-memory address space.
    function automatic bit img_width_ok(input int img_width, input int addr_width);
        return (img_width >= 2) && (img_width <= (1 << addr_width));
    endfunction

endpackage

// File: rtl/line_ring_buffer_if.sv
// line_ring_buffer_if
//   Pixel-in / column-out bundle of the line ring buffer.
//   Ports:
//     sof_i      start-of-frame pulse (source -> buffer)
//     pix_vld_i  pixel strobe          (source -> buffer)
//     pix_i      raster pixel          (source -> buffer)
//     col_vld_o  column valid          (buffer -> sink)
//     col_o      vertical column, row k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//     col_x_o    column index of col_o
//     win_rdy_o  column holds LINE_NUM real lines of the current frame
//   Handshake: strobe-only, no backpressure. A pixel is transferred on every
//   rising edge where pix_vld_i=1; a column is presented on every edge where
//   col_vld_o=1, exactly one cycle after its pixel. The sink must accept it.
interface line_ring_buffer_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_NUM   = 18
);
    logic                           sof_i;
    logic                           pix_vld_i;
    logic [DATA_WIDTH-1:0]          pix_i;
    logic                           col_vld_o;
    logic [LINE_NUM*DATA_WIDTH-1:0] col_o;
    logic [ADDR_WIDTH-1:0]          col_x_o;
    logic                           win_rdy_o;

    modport master (
        output sof_i, pix_vld_i, pix_i,
        input  col_vld_o, col_o, col_x_o, win_rdy_o
    );

    modport slave (
        input  sof_i, pix_vld_i, pix_i,
        output col_vld_o, col_o, col_x_o, win_rdy_o
    );
endinterface

// File: rtl/line_ring_buffer_sram.sv
// line_sram
//   Single-port line memory, one clock, registered read with 1-cycle latency,
//   read-first: a read and write to the same address in one cycle returns the
//   old contents. Only the read register is reset; the array is never cleared.
//   Ports: clk, rst_n (sync, active-low, clears rdata), we, re, addr, wdata, rdata.
module line_sram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata holds between reads so an idle cycle leaves the column untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/line_ring_buffer.sv
// line_ring_buffer
//   Stores the last LINE_NUM raster lines in a ring of line memories and, for
//   every incoming pixel, emits the vertical column at that x position one
//   cycle later: oldest line at row 0, the incoming pixel itself at the top row.
//   Ports: clk, rst_n (sync, active-low), bus (line_ring_buffer_if.slave).
module line_ring_buffer
    import line_ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 12,
    parameter int IMG_WIDTH    = 4096,
    parameter int BLOCK_RADIUS = 2,
    parameter int WIN_RADIUS   = 6
) (
    input logic               clk,
    input logic               rst_n,
    line_ring_buffer_if.slave bus
);
    localparam int LINE_NUM = calc_line_num(BLOCK_RADIUS, WIN_RADIUS);
    localparam int LINE_W   = $clog2(LINE_NUM);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0]     LINE_LAST = LINE_W'(LINE_NUM - 1);

    if (!img_width_ok(IMG_WIDTH, ADDR_WIDTH)) begin : g_bad_img_width
        $error("line_ring_buffer: IMG_WIDTH must satisfy 2 <= IMG_WIDTH <= 2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] col_cnt, col_eff;
    logic [LINE_W-1:0]     wr_line, line_eff;
    logic [LINE_W-1:0]     fill_cnt, fill_eff;
    logic                  wr_en;

    logic                  col_vld_q, win_rdy_q;
    logic [ADDR_WIDTH-1:0] col_x_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [LINE_W-1:0]     rot_q;

    logic [DATA_WIDTH-1:0]          rd_data [LINE_NUM];
    logic [LINE_NUM*DATA_WIDTH-1:0] col_mux;
    int                             src;

    // Start of frame takes effect in the same cycle, so a pixel arriving with
    // sof_i is treated as column 0 of line 0.
    always_comb begin
        col_eff  = col_cnt;
        line_eff = wr_line;
        fill_eff = fill_cnt;
        if (bus.sof_i) begin
            col_eff  = '0;
            line_eff = '0;
            fill_eff = '0;
        end
    end

    // Reset wins over the strobe: a pixel presented during reset is dropped.
    assign wr_en = rst_n && bus.pix_vld_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            wr_line  <= '0;
            fill_cnt <= '0;
        end else if (bus.pix_vld_i) begin
            if (col_eff == COL_LAST) begin
                col_cnt  <= '0;
                wr_line  <= (line_eff == LINE_LAST) ? '0 : line_eff + 1'b1;
                fill_cnt <= (fill_eff == LINE_LAST) ? fill_eff : fill_eff + 1'b1;
            end else begin
                col_cnt  <= col_eff + 1'b1;
                wr_line  <= line_eff;
                fill_cnt <= fill_eff;
            end
        end else if (bus.sof_i) begin
            col_cnt  <= '0;
            wr_line  <= '0;
            fill_cnt <= '0;
        end
    end

    for (genvar g = 0; g < LINE_NUM; g++) begin : g_line
        line_sram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_sram (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (wr_en && (line_eff == LINE_W'(g))),
            .re   (wr_en),
            .addr (col_eff),
            .wdata(bus.pix_i),
            .rdata(rd_data[g])
        );
    end

    // Output-side registers; everything except col_vld/win_rdy holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_vld_q <= 1'b0;
            win_rdy_q <= 1'b0;
            col_x_q   <= '0;
            pix_q     <= '0;
            rot_q     <= '0;
        end else begin
            col_vld_q <= bus.pix_vld_i;
            win_rdy_q <= bus.pix_vld_i && (fill_eff == LINE_LAST);
            if (bus.pix_vld_i) begin
                col_x_q <= col_eff;
                pix_q   <= bus.pix_i;
                rot_q   <= line_eff;
            end
        end
    end

    // Barrel rotation driven by the registered write line: row k comes from
    // memory (rot_q - (LINE_NUM-1-k)) mod LINE_NUM == (rot_q + k + 1) mod LINE_NUM.
    // The top row bypasses memory with the registered incoming pixel.
    always_comb begin
        col_mux = '0;
        src     = 0;
        for (int k = 0; k < LINE_NUM - 1; k++) begin
            src = int'(rot_q) + k + 1;
            if (src >= LINE_NUM) begin
                src = src - LINE_NUM;
            end
            col_mux[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[src[LINE_W-1:0]];
        end
        col_mux[(LINE_NUM-1)*DATA_WIDTH +: DATA_WIDTH] = pix_q;
    end

    assign bus.col_vld_o = col_vld_q;
    assign bus.win_rdy_o = win_rdy_q;
    assign bus.col_x_o   = col_x_q;
    assign bus.col_o     = col_mux;
endmodule

// File: tb/tb_line_ring_buffer.sv
// tb_line_ring_buffer
//   Directed bench for line_ring_buffer with LINE_NUM=4, IMG_WIDTH=8, DATA_WIDTH=12.
module tb_line_ring_buffer;
    localparam int DW = 12;
    localparam int AW = 4;
    localparam int IW = 8;
    localparam int LN = 4;
    localparam int CW = LN * DW;

    typedef struct packed {
        logic          rdy;
        logic [AW-1:0] x;
        logic [CW-1:0] col;
    } obs_t;
    localparam int OW = $bits(obs_t);

    typedef struct {
        int            line;
        int            col;
        logic [CW-1:0] exp_col;
        bit            full;
        logic [AW-1:0] exp_x;
        logic          exp_rdy;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_ring_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_NUM(LN)) bus ();

    line_ring_buffer #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .IMG_WIDTH   (IW),
        .BLOCK_RADIUS(0),
        .WIN_RADIUS  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [OW-1:0] exp_q[$];

    logic [DW-1:0] mem_m [LN][IW];
    bit            mem_v [LN][IW];
    int            m_line = 0;
    int            m_col = 0;
    logic [CW-1:0] last_col = '0;
    logic [CW-1:0] last_mask = '1;
    logic [AW-1:0] last_x = '0;

    logic          got_vld, got_rdy;
    logic [AW-1:0] got_x;
    logic [CW-1:0] got_col;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (line %0d col %0d)",
                     name, act, exp, m_line, m_col);
        end
    endtask

    task automatic sample();
        got_vld = bus.col_vld_o;
        got_rdy = bus.win_rdy_o;
        got_x   = bus.col_x_o;
        got_col = bus.col_o;
    endtask

    // ---------------- driver + model ----------------
    // Model tracks the absolute line number inside the frame; row k of a column
    // is absolute line (m_line - (LN-1-k)), held physically at that line mod LN.
    task automatic step(input logic sof, input logic vld, input logic [DW-1:0] pix,
                        output obs_t e);
        logic [CW-1:0] exp_col, mask;
        logic          exp_rdy;
        logic [AW-1:0] exp_x;
        int            r;
        if (sof) begin
            m_line = 0;
            m_col  = 0;
        end
        exp_col = last_col;
        mask    = last_mask;
        exp_x   = last_x;
        exp_rdy = 1'b0;
        if (vld) begin
            mask = '0;
            for (int k = 0; k < LN - 1; k++) begin
                r = (m_line + LN - (LN - 1 - k)) % LN;
                if (mem_v[r][m_col]) begin
                    exp_col[k*DW +: DW] = mem_m[r][m_col];
                    mask[k*DW +: DW]    = '1;
                end
            end
            exp_col[(LN-1)*DW +: DW] = pix;
            mask[(LN-1)*DW +: DW]    = '1;
            exp_rdy = (m_line >= LN - 1);
            exp_x   = AW'(m_col);
            mem_m[m_line % LN][m_col] = pix;
            mem_v[m_line % LN][m_col] = 1'b1;
            m_col++;
            if (m_col == IW) begin
                m_col = 0;
                m_line++;
            end
        end
        bus.sof_i     = sof;
        bus.pix_vld_i = vld;
        bus.pix_i     = pix;
        @(posedge clk);
        #1;
        sample();
        check("col_vld", got_vld, vld);
        check("win_rdy", got_rdy, exp_rdy);
        check("col_x", got_x, exp_x);
        check("col_o", got_col & mask, exp_col & mask);
        last_col  = exp_col;
        last_mask = mask;
        last_x    = exp_x;
        e.rdy = exp_rdy;
        e.x   = exp_x;
        e.col = exp_col;
    endtask

    task automatic model_reset();
        m_line    = 0;
        m_col     = 0;
        last_col  = '0;
        last_mask = '1;
        last_x    = '0;
    endtask

    // ---------------- test ----------------
    initial begin
        obs_t e, q;
        int   n_vld, n_rdy, gaps;

        vecs[0] = '{line: 2, col: 7, exp_col: 48'h027000000000, full: 0, exp_x: 4'd7, exp_rdy: 1'b0};
        vecs[1] = '{line: 3, col: 0, exp_col: 48'h030020010000, full: 1, exp_x: 4'd0, exp_rdy: 1'b1};
        vecs[2] = '{line: 3, col: 5, exp_col: 48'h035025015005, full: 1, exp_x: 4'd5, exp_rdy: 1'b1};
        vecs[3] = '{line: 3, col: 7, exp_col: 48'h037027017007, full: 1, exp_x: 4'd7, exp_rdy: 1'b1};
        vecs[4] = '{line: 4, col: 0, exp_col: 48'h040030020010, full: 1, exp_x: 4'd0, exp_rdy: 1'b1};
        vecs[5] = '{line: 5, col: 2, exp_col: 48'h052042032022, full: 1, exp_x: 4'd2, exp_rdy: 1'b1};

        // Reset with a pixel strobe held high: it must be dropped.
        bus.sof_i     = 1'b1;
        bus.pix_vld_i = 1'b1;
        bus.pix_i     = 12'h7FF;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample();
        check("rst_col_vld", got_vld, 1'b0);
        check("rst_win_rdy", got_rdy, 1'b0);
        check("rst_col_x", got_x, '0);
        check("rst_col_o", got_col, '0);
        rst_n = 1'b1;
        model_reset();

        // Frame 1: six gap-free lines, pixel = 16*line + col.
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < IW; c++) begin
                step(l == 0 && c == 0, 1'b1, DW'(16 * l + c), e);
                exp_q.push_back(e);
                for (int v = 0; v < 6; v++) begin
                    if (vecs[v].line == l && vecs[v].col == c) begin
                        check("vec_x", got_x, vecs[v].exp_x);
                        check("vec_rdy", got_rdy, vecs[v].exp_rdy);
                        if (vecs[v].full)
                            check("vec_col", got_col, vecs[v].exp_col);
                        else
                            check("vec_top", got_col[CW-1 -: DW], vecs[v].exp_col[CW-1 -: DW]);
                    end
                end
            end
        end

        // Frame 2: same pixels with random idle gaps; output must match frame 1.
        n_vld = 0;
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < IW; c++) begin
                gaps = $urandom_range(0, 5);
                for (int g = 0; g < gaps; g++) begin
                    step(1'b0, 1'b0, DW'($urandom_range(0, 4095)), e);
                    if (got_vld) n_vld++;
                end
                step(l == 0 && c == 0, 1'b1, DW'(16 * l + c), e);
                if (got_vld) begin
                    n_vld++;
                    if (exp_q.size() == 0) begin
                        check("gap_queue_empty", 1'b1, 1'b0);
                    end else begin
                        q = obs_t'(exp_q.pop_front());
                        check("gap_x", got_x, q.x);
                        check("gap_rdy", got_rdy, q.rdy);
                        if (q.rdy) check("gap_col", got_col, q.col);
                    end
                end
            end
        end
        check("gap_vld_count", n_vld, 6 * IW);

        // Frame 3: sof with a pixel at line 2 col 4 restarts the frame.
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < IW; c++) begin
                if (l == 2 && c == 4) break;
                step(l == 0 && c == 0, 1'b1, DW'(12'h100 + 16 * l + c), e);
            end
        end
        step(1'b1, 1'b1, 12'hABC, e);
        check("sof_col_x", got_x, 4'd0);
        check("sof_win_rdy", got_rdy, 1'b0);
        check("sof_top_row", got_col[CW-1 -: DW], 12'hABC);
        n_rdy = 0;
        for (int i = 1; i < 3 * IW; i++) begin
            step(1'b0, 1'b1, DW'(12'h180 + i), e);
            if (got_rdy) n_rdy++;
        end
        check("sof_rdy_early", n_rdy, 0);
        step(1'b0, 1'b1, 12'h1F0, e);
        check("sof_rdy_l3c0", got_rdy, 1'b1);
        check("sof_x_l3c0", got_x, 4'd0);

        // Frame 4: lone sof, then reset mid-line 3 with a pixel strobe.
        step(1'b1, 1'b0, 12'h000, e);
        for (int i = 0; i < 3 * IW + 3; i++) begin
            step(1'b0, 1'b1, DW'(12'h200 + i), e);
        end
        bus.sof_i     = 1'b0;
        bus.pix_vld_i = 1'b1;
        bus.pix_i     = 12'hFFF;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        sample();
        check("mid_rst_col_vld", got_vld, 1'b0);
        check("mid_rst_win_rdy", got_rdy, 1'b0);
        check("mid_rst_col_x", got_x, '0);
        check("mid_rst_col_o", got_col, '0);
        rst_n = 1'b1;
        model_reset();
        n_rdy = 0;
        for (int i = 0; i < 3 * IW; i++) begin
            step(1'b0, 1'b1, DW'(12'h300 + i), e);
            if (got_rdy) n_rdy++;
        end
        check("post_rst_rdy_early", n_rdy, 0);
        n_rdy = 0;
        for (int i = 0; i < IW; i++) begin
            step(1'b0, 1'b1, DW'(12'h380 + i), e);
            if (got_rdy) n_rdy++;
        end
        check("post_rst_rdy_line3", n_rdy, IW);
        step(1'b0, 1'b0, 12'h000, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
